// File: rtl/kugelblitz_pkg.sv
// Shared definitions for the kugelblitz EtherType filter: register map, rule
// field layout, FSM encoding and first-beat EtherType extraction.
package kugelblitz_pkg;

    localparam int unsigned KG_REG_CTRL      = 32'h00;
    localparam int unsigned KG_REG_PASS_CNT  = 32'h04;
    localparam int unsigned KG_REG_DROP_CNT  = 32'h08;
    localparam int unsigned KG_REG_RULE_BASE = 32'h10;
    localparam int unsigned KG_RULE_STRIDE   = 4;

    localparam int unsigned KG_CTRL_W            = 2;
    localparam int unsigned KG_CTRL_FILTER_EN    = 0;
    localparam int unsigned KG_CTRL_DEFAULT_DROP = 1;

    localparam int unsigned KG_ETYPE_W        = 16;
    localparam int unsigned KG_RULE_ETYPE_LSB = 0;
    localparam int unsigned KG_RULE_EN_BIT    = 16;
    localparam int unsigned KG_RULE_DROP_BIT  = 17;
    localparam int unsigned KG_RULE_W         = 18;
    localparam int unsigned KG_IDX_W          = 4;

    localparam logic [1:0] KG_ST_FIRST = 2'd0;
    localparam logic [1:0] KG_ST_PASS  = 2'd1;
    localparam logic [1:0] KG_ST_DROP  = 2'd2;

    // Bytes 12..13 of the Ethernet header, network byte order.
    function automatic logic [KG_ETYPE_W-1:0] kg_extract_etype(input logic [127:0] beat);
        return {beat[103:96], beat[111:104]};
    endfunction

endpackage

// File: rtl/kugelblitz_rule_match.sv
// Combinational EtherType classifier: lowest-index enabled matching rule wins,
// otherwise default_drop decides; everything passes while the filter is off.
module kugelblitz_rule_match
    import kugelblitz_pkg::*;
#(
    parameter int unsigned RULE_COUNT = 8
) (
    input  logic [KG_ETYPE_W-1:0]           etype,
    input  logic [RULE_COUNT*KG_RULE_W-1:0] rules,
    input  logic [KG_CTRL_W-1:0]            ctrl,
    output logic                            drop_decision_c,
    output logic                            matched_c,
    output logic [KG_IDX_W-1:0]             matched_index_c
);

    logic [RULE_COUNT-1:0] hit_vec;
    logic [RULE_COUNT-1:0] drop_vec;
    logic [RULE_COUNT-1:0] hit_low;

    for (genvar g = 0; g < RULE_COUNT; g++) begin : g_rule
        localparam int unsigned BASE = g * KG_RULE_W;
        assign hit_vec[g]  = rules[BASE + KG_RULE_EN_BIT] &&
                             (rules[BASE + KG_RULE_ETYPE_LSB +: KG_ETYPE_W] == etype);
        assign drop_vec[g] = rules[BASE + KG_RULE_DROP_BIT];
    end

    // Isolate the lowest set hit bit to get rule priority.
    assign hit_low = hit_vec & (~hit_vec + RULE_COUNT'(1));

    always_comb begin
        matched_c       = |hit_vec;
        matched_index_c = '0;
        for (int i = 0; i < RULE_COUNT; i++) begin
            if (hit_low[i]) begin
                matched_index_c = KG_IDX_W'(i);
            end
        end
        if (!ctrl[KG_CTRL_FILTER_EN]) begin
            drop_decision_c = 1'b0;
        end else if (matched_c) begin
            drop_decision_c = |(hit_low & drop_vec);
        end else begin
            drop_decision_c = ctrl[KG_CTRL_DEFAULT_DROP];
        end
    end

endmodule

// File: rtl/kugelblitz_ethertype_filter.sv
// Per-port AXI-Stream frame filter: classifies each frame on its first beat by
// EtherType, forwards or drops the whole frame, and keeps pass/drop counters.
module kugelblitz_ethertype_filter
    import kugelblitz_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 512,
    parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH      = 1,
    parameter int unsigned RULE_COUNT      = 8,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned CFG_ADDR_WIDTH  = 8
) (
    input  logic                       kg_clk,
    input  logic                       kg_rst_n,
    input  logic                       kg_cfg_wr_en,
    input  logic                       kg_cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0]  kg_cfg_addr,
    input  logic [31:0]                kg_cfg_wdata,
    output logic [31:0]                kg_cfg_rdata,
    input  logic [AXIS_DATA_WIDTH-1:0] kg_s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] kg_s_axis_tkeep,
    input  logic                       kg_s_axis_tvalid,
    input  logic                       kg_s_axis_tlast,
    input  logic [USER_WIDTH-1:0]      kg_s_axis_tuser,
    output logic                       kg_s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] kg_m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] kg_m_axis_tkeep,
    output logic                       kg_m_axis_tvalid,
    output logic                       kg_m_axis_tlast,
    output logic [USER_WIDTH-1:0]      kg_m_axis_tuser,
    input  logic                       kg_m_axis_tready
);

    localparam int unsigned RULES_W = RULE_COUNT * KG_RULE_W;

    logic [1:0]                 state_q, state_d;
    logic [KG_CTRL_W-1:0]       ctrl_q, ctrl_d;
    logic [RULES_W-1:0]         rules_q, rules_d;
    logic [CNT_WIDTH-1:0]       pass_cnt_q, pass_cnt_d;
    logic [CNT_WIDTH-1:0]       drop_cnt_q, drop_cnt_d;
    logic [31:0]                rdata_q, rdata_d;
    logic                       m_tvalid_q, m_tvalid_d;
    logic [AXIS_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [AXIS_KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
    logic                       m_tlast_q, m_tlast_d;
    logic [USER_WIDTH-1:0]      m_tuser_q, m_tuser_d;

    logic [KG_ETYPE_W-1:0]      etype_c;
    logic                       drop_decision_c;
    logic                       matched_c;
    logic [KG_IDX_W-1:0]        matched_index_c;
    logic                       in_hs_c;
    logic                       frame_drop_c;
    logic                       fwd_beat_c;
    logic [RULE_COUNT-1:0]      rule_sel_c;
    logic                       unused_dbg;

    assign etype_c = kg_extract_etype(kg_s_axis_tdata[127:0]);

    kugelblitz_rule_match #(
        .RULE_COUNT (RULE_COUNT)
    ) u_rule_match (
        .etype           (etype_c),
        .rules           (rules_q),
        .ctrl            (ctrl_q),
        .drop_decision_c (drop_decision_c),
        .matched_c       (matched_c),
        .matched_index_c (matched_index_c)
    );

    // Drop-state beats never touch the output register, so they drain freely;
    // a first beat waits for a free output slot so its decision is never lost.
    assign kg_s_axis_tready = (state_q == KG_ST_DROP) || !m_tvalid_q || kg_m_axis_tready;
    assign in_hs_c          = kg_s_axis_tvalid && kg_s_axis_tready;
    assign frame_drop_c     = (state_q == KG_ST_DROP) ||
                              ((state_q == KG_ST_FIRST) && drop_decision_c);
    assign fwd_beat_c       = in_hs_c && !frame_drop_c;

    for (genvar g = 0; g < RULE_COUNT; g++) begin : g_rule_reg
        localparam logic [CFG_ADDR_WIDTH-1:0] RULE_ADDR =
            CFG_ADDR_WIDTH'(KG_REG_RULE_BASE + KG_RULE_STRIDE * g);
        assign rule_sel_c[g] = (kg_cfg_addr == RULE_ADDR);
        assign rules_d[g*KG_RULE_W +: KG_RULE_W] = (kg_cfg_wr_en && rule_sel_c[g]) ?
            kg_cfg_wdata[KG_RULE_W-1:0] : rules_q[g*KG_RULE_W +: KG_RULE_W];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            KG_ST_FIRST: begin
                if (in_hs_c && !kg_s_axis_tlast) begin
                    state_d = drop_decision_c ? KG_ST_DROP : KG_ST_PASS;
                end
            end
            KG_ST_PASS, KG_ST_DROP: begin
                if (in_hs_c && kg_s_axis_tlast) begin
                    state_d = KG_ST_FIRST;
                end
            end
            default: state_d = KG_ST_FIRST;
        endcase
    end

    // Single registered output slot; holds its contents while stalled.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        if (fwd_beat_c) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = kg_s_axis_tdata;
            m_tkeep_d  = kg_s_axis_tkeep;
            m_tlast_d  = kg_s_axis_tlast;
            m_tuser_d  = kg_s_axis_tuser;
        end else if (kg_m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // Counter clears are applied after increments so a same-cycle clear wins.
    always_comb begin
        ctrl_d     = ctrl_q;
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (in_hs_c && kg_s_axis_tlast) begin
            if (frame_drop_c) begin
                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end else begin
                pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
            end
        end
        if (kg_cfg_wr_en) begin
            if (kg_cfg_addr == CFG_ADDR_WIDTH'(KG_REG_CTRL)) begin
                ctrl_d = kg_cfg_wdata[KG_CTRL_W-1:0];
            end
            if (kg_cfg_addr == CFG_ADDR_WIDTH'(KG_REG_PASS_CNT)) begin
                pass_cnt_d = '0;
            end
            if (kg_cfg_addr == CFG_ADDR_WIDTH'(KG_REG_DROP_CNT)) begin
                drop_cnt_d = '0;
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (kg_cfg_rd_en) begin
            rdata_d = '0;
            if (kg_cfg_addr == CFG_ADDR_WIDTH'(KG_REG_CTRL)) begin
                rdata_d = 32'(ctrl_q);
            end
            if (kg_cfg_addr == CFG_ADDR_WIDTH'(KG_REG_PASS_CNT)) begin
                rdata_d = 32'(pass_cnt_q);
            end
            if (kg_cfg_addr == CFG_ADDR_WIDTH'(KG_REG_DROP_CNT)) begin
                rdata_d = 32'(drop_cnt_q);
            end
            for (int i = 0; i < RULE_COUNT; i++) begin
                if (rule_sel_c[i]) begin
                    rdata_d = 32'(rules_q[i*KG_RULE_W +: KG_RULE_W]);
                end
            end
        end
    end

    always_ff @(posedge kg_clk or negedge kg_rst_n) begin
        if (!kg_rst_n) begin
            state_q    <= KG_ST_FIRST;
            ctrl_q     <= '0;
            rules_q    <= '0;
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
            rdata_q    <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            rules_q    <= rules_d;
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            rdata_q    <= rdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
        end
    end

    assign kg_cfg_rdata     = rdata_q;
    assign kg_m_axis_tvalid = m_tvalid_q;
    assign kg_m_axis_tdata  = m_tdata_q;
    assign kg_m_axis_tkeep  = m_tkeep_q;
    assign kg_m_axis_tlast  = m_tlast_q;
    assign kg_m_axis_tuser  = m_tuser_q;

    // Debug match info and upper write-data bits have no consumer here.
    assign unused_dbg = ^{matched_c, matched_index_c, kg_cfg_wdata[31:KG_RULE_W]};

endmodule

// File: tb/tb_kugelblitz_ethertype_filter.sv
// Directed bench for kugelblitz_ethertype_filter: scoreboard of expected output
// beats, register readback of counters/config, and AXI-Stream stability checks.
module tb_kugelblitz_ethertype_filter;

    localparam int unsigned DW = 128;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic          kg_clk;
    logic          kg_rst_n;
    logic          kg_cfg_wr_en;
    logic          kg_cfg_rd_en;
    logic [7:0]    kg_cfg_addr;
    logic [31:0]   kg_cfg_wdata;
    logic [31:0]   kg_cfg_rdata;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tvalid;
    logic          s_tlast;
    logic [0:0]    s_tuser;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tlast;
    logic [0:0]    m_tuser;
    logic          m_tready;

    int    errors = 0;
    int    checks = 0;
    bit    rand_ready = 0;
    int    stalls;
    beat_t exp_q[$];

    kugelblitz_ethertype_filter #(
        .AXIS_DATA_WIDTH (DW),
        .AXIS_KEEP_WIDTH (KW),
        .USER_WIDTH      (1),
        .RULE_COUNT      (8),
        .CNT_WIDTH       (CW),
        .CFG_ADDR_WIDTH  (8)
    ) dut (
        .kg_clk           (kg_clk),
        .kg_rst_n         (kg_rst_n),
        .kg_cfg_wr_en     (kg_cfg_wr_en),
        .kg_cfg_rd_en     (kg_cfg_rd_en),
        .kg_cfg_addr      (kg_cfg_addr),
        .kg_cfg_wdata     (kg_cfg_wdata),
        .kg_cfg_rdata     (kg_cfg_rdata),
        .kg_s_axis_tdata  (s_tdata),
        .kg_s_axis_tkeep  (s_tkeep),
        .kg_s_axis_tvalid (s_tvalid),
        .kg_s_axis_tlast  (s_tlast),
        .kg_s_axis_tuser  (s_tuser),
        .kg_s_axis_tready (s_tready),
        .kg_m_axis_tdata  (m_tdata),
        .kg_m_axis_tkeep  (m_tkeep),
        .kg_m_axis_tvalid (m_tvalid),
        .kg_m_axis_tlast  (m_tlast),
        .kg_m_axis_tuser  (m_tuser),
        .kg_m_axis_tready (m_tready)
    );

    initial begin
        kg_clk = 1'b0;
        forever #5 kg_clk = ~kg_clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
        kg_cfg_wr_en = 1'b1;
        kg_cfg_addr  = addr;
        kg_cfg_wdata = data;
        @(posedge kg_clk); #1;
        kg_cfg_wr_en = 1'b0;
    endtask

    task automatic cfg_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        kg_cfg_rd_en = 1'b1;
        kg_cfg_addr  = addr;
        @(posedge kg_clk); #1;
        kg_cfg_rd_en = 1'b0;
        chk(tag, 128'(kg_cfg_rdata), 128'(exp));
    endtask

    // Drives one frame; expected beats are queued when driven if the frame should pass.
    task automatic send_frame(input logic [15:0] et, input int n, input bit pass, output int st);
        beat_t b;
        logic  acc;
        int    w;
        st = 0;
        for (int i = 0; i < n; i++) begin
            b.data          = {$urandom(), $urandom(), $urandom(), $urandom()};
            b.data[111:96]  = {et[7:0], et[15:8]};
            b.keep          = (i == n - 1) ? KW'($urandom_range(1, 65535)) : '1;
            b.last          = (i == n - 1);
            b.user          = 1'($urandom_range(0, 1));
            if (pass) exp_q.push_back(b);
            s_tdata  = b.data;
            s_tkeep  = b.keep;
            s_tlast  = b.last;
            s_tuser  = b.user;
            s_tvalid = 1'b1;
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 200) begin
                @(negedge kg_clk);
                acc = s_tready;
                @(posedge kg_clk); #1;
                if (!acc) w++;
            end
            checks++;
            assert (acc) else begin
                errors++;
                $error("FAIL accept_timeout: got tready=0 for %0d cycles expected 1", w);
            end
            if (i > 0) st += w;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge kg_clk); #1;
            w++;
        end
        @(posedge kg_clk); #1;
        chk(tag, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic ready_driver();
        m_tready = 1'b1;
        forever begin
            @(posedge kg_clk); #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // Compares handshaked output beats and checks stability across stalls.
    task automatic monitor();
        beat_t got, prev, e;
        logic  pv, pr;
        pv = 1'b0;
        pr = 1'b1;
        prev = '0;
        forever begin
            @(negedge kg_clk);
            got = {m_tdata, m_tkeep, m_tlast, m_tuser[0]};
            if (pv && !pr) begin
                checks++;
                assert (m_tvalid === 1'b1 && got === prev) else begin
                    errors++;
                    $error("FAIL stall_stable: got v=%b %h expected v=1 %h", m_tvalid, got, prev);
                end
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat: got %h expected no output", got);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (got === e) else begin
                        errors++;
                        $error("FAIL out_beat: got %h expected %h", got, e);
                    end
                end
            end
            prev = got;
            pv   = m_tvalid;
            pr   = m_tready;
        end
    endtask

    initial begin
        kg_rst_n     = 1'b0;
        kg_cfg_wr_en = 1'b0;
        kg_cfg_rd_en = 1'b0;
        kg_cfg_addr  = '0;
        kg_cfg_wdata = '0;
        s_tdata      = '0;
        s_tkeep      = '0;
        s_tvalid     = 1'b0;
        s_tlast      = 1'b0;
        s_tuser      = '0;
        m_tready     = 1'b1;
        fork
            ready_driver();
        join_none
        repeat (3) @(posedge kg_clk);
        #1;
        chk("reset_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("reset_m_tdata", m_tdata, 128'(0));
        chk("reset_m_tkeep_last_user", 128'({m_tkeep, m_tlast, m_tuser}), 128'(0));
        chk("reset_rdata", 128'(kg_cfg_rdata), 128'(0));
        kg_rst_n = 1'b1;
        @(posedge kg_clk); #1;
        fork
            monitor();
        join_none
        chk("idle_s_tready", 128'(s_tready), 128'(1));
        cfg_read("reset_ctrl", 8'h00, 32'h0);
        cfg_read("reset_pass_cnt", 8'h04, 32'h0);
        cfg_read("reset_drop_cnt", 8'h08, 32'h0);
        cfg_read("reset_rule0", 8'h10, 32'h0);

        // Filter disabled: everything passes, one cycle of latency.
        send_frame(16'h0800, 3, 1, stalls);
        chk("latency_last_beat", 128'({m_tvalid, m_tlast}), 128'(2'b11));
        drain("drain_disabled");
        cfg_read("disabled_pass_cnt", 8'h04, 32'd1);
        cfg_read("disabled_drop_cnt", 8'h08, 32'd0);

        // ARP dropped by rule0, IPv4 passes.
        cfg_write(8'h04, 32'h0);
        cfg_write(8'h08, 32'h0);
        cfg_write(8'h00, 32'h1);
        cfg_write(8'h10, 32'h0003_0806);
        send_frame(16'h0806, 1, 0, stalls);
        chk("arp_no_output", 128'(m_tvalid), 128'(0));
        send_frame(16'h0800, 2, 1, stalls);
        drain("drain_arp");
        cfg_read("arp_pass_cnt", 8'h04, 32'd1);
        cfg_read("arp_drop_cnt", 8'h08, 32'd1);
        cfg_read("rule0_readback", 8'h10, 32'h0003_0806);

        // Priority: rule1 passes IPv6 ahead of rule3; unmatched falls to default_drop.
        cfg_write(8'h00, 32'h3);
        cfg_write(8'h14, 32'h0001_86DD);
        cfg_write(8'h1C, 32'h0003_86DD);
        send_frame(16'h86DD, 2, 1, stalls);
        send_frame(16'h88CC, 1, 0, stalls);
        drain("drain_priority");
        cfg_read("prio_pass_cnt", 8'h04, 32'd2);
        cfg_read("prio_drop_cnt", 8'h08, 32'd2);
        cfg_read("rule1_readback", 8'h14, 32'h0001_86DD);

        // Backpressure on a long passing frame, dropped frame drains behind it.
        rand_ready = 1'b1;
        send_frame(16'h86DD, 10, 1, stalls);
        send_frame(16'h88CC, 5, 0, stalls);
        chk("drop_drain_no_stall", 128'(stalls), 128'(0));
        rand_ready = 1'b0;
        drain("drain_backpressure");
        cfg_read("bp_pass_cnt", 8'h04, 32'd3);
        cfg_read("bp_drop_cnt", 8'h08, 32'd3);

        // Rule change during beat 2 only affects the next frame.
        cfg_write(8'h00, 32'h1);
        fork
            send_frame(16'h0800, 4, 1, stalls);
            begin
                @(posedge kg_clk); #1;
                cfg_write(8'h10, 32'h0003_0800);
            end
        join
        send_frame(16'h0800, 2, 0, stalls);
        drain("drain_midframe");
        cfg_read("mid_pass_cnt", 8'h04, 32'd4);
        cfg_read("mid_drop_cnt", 8'h08, 32'd4);

        // Clear in the same cycle as a pass tlast wins.
        fork
            send_frame(16'h86DD, 1, 1, stalls);
            cfg_write(8'h04, 32'h0);
        join
        drain("drain_clear_race");
        cfg_read("race_pass_cnt", 8'h04, 32'd0);
        cfg_read("race_drop_cnt", 8'h08, 32'd4);

        // Unmapped addresses read 0 and ignore writes.
        cfg_write(8'h0C, 32'hFFFF_FFFF);
        cfg_read("unmapped_0c", 8'h0C, 32'h0);
        cfg_read("unmapped_rule8", 8'h30, 32'h0);
        cfg_read("ctrl_after_unmapped", 8'h00, 32'h1);

        // Counter wraps modulo 2^CW.
        cfg_write(8'h08, 32'h0);
        for (int i = 0; i < 15; i++) begin
            send_frame(16'h0800, 1, 0, stalls);
        end
        cfg_read("drop_cnt_max", 8'h08, 32'd15);
        send_frame(16'h0800, 1, 0, stalls);
        cfg_read("drop_cnt_wrap", 8'h08, 32'd0);
        cfg_read("pass_cnt_after_wrap", 8'h04, 32'd0);

        drain("final_queue_empty");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
